// File: rtl/ntt_bf_scheduler.sv
// ntt_bf_scheduler
// Stage/address sequencer for a single radix-2 butterfly running an
// N = 2^LOG_N point NTT (Cooley-Tukey) or INTT (Gentleman-Sande).
// One butterfly is issued per cycle. A drain bubble of PIPE_LAT cycles
// separates stages so that every write of a stage lands before the first
// read of the next stage.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start, mode          start request (IDLE only), 0 = NTT / 1 = INTT
//   busy, done           busy from first issue through last write, done pulse
//   sel_ntt              latched mode, stable for the whole transform
//   rd_en, rd_addr_u/v   butterfly issue strobe and coefficient read addresses
//   tw_addr              twiddle ROM address
//   wr_en, wr_addr_u/v   write-back strobe/addresses, PIPE_LAT after issue
//   stage                current stage index
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start
// S_RUN   | issuing one butterfly per cycle, j = 0 .. N/2-1
// S_DRAIN | PIPE_LAT cycles without issue while the pipeline empties
// S_FIN   | one-cycle done pulse

module ntt_bf_scheduler #(
  parameter int LOG_N    = 9,
  parameter int PIPE_LAT = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic             sel_ntt,
  output logic             rd_en,
  output logic [LOG_N-1:0] rd_addr_u,
  output logic [LOG_N-1:0] rd_addr_v,
  output logic [LOG_N-1:0] tw_addr,
  output logic             wr_en,
  output logic [LOG_N-1:0] wr_addr_u,
  output logic [LOG_N-1:0] wr_addr_v,
  output logic [3:0]       stage
);

  localparam int JW = LOG_N - 1;
  localparam int CW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam int DW = 2 * LOG_N + 1;
  localparam logic [3:0]    LAST_STAGE = 4'(LOG_N - 1);
  localparam logic [JW-1:0] J_LAST     = {JW{1'b1}};
  localparam logic [CW-1:0] DRAIN_INIT = CW'(PIPE_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

  typedef struct packed {
    logic [LOG_N-1:0] u;
    logic [LOG_N-1:0] v;
    logic [LOG_N-1:0] tw;
  } addr_t;

  state_t        state;
  logic [JW-1:0] j;
  logic [CW-1:0] cnt;

  logic [JW-1:0] issue_j;
  logic [3:0]    issue_stage;
  logic          issue_mode;
  addr_t         issue_a;

  // Insert a 0/1 bit at position b of j to form the u/v pair; the group
  // index (j >> b) offsets the per-stage twiddle base.
  function automatic addr_t gen_addr(input logic [JW-1:0] jv,
                                     input logic [3:0]    sv,
                                     input logic          mv);
    addr_t            a;
    logic [3:0]       b;
    logic [LOG_N-1:0] jx;
    logic [LOG_N-1:0] one_b;
    logic [LOG_N-1:0] mask;
    logic [LOG_N-1:0] base;
    b     = mv ? sv : (LAST_STAGE - sv);
    jx    = {1'b0, jv};
    one_b = LOG_N'(1) << b;
    mask  = one_b - LOG_N'(1);
    base  = mv ? ((LOG_N'(1) << LAST_STAGE) >> sv) : (LOG_N'(1) << sv);
    a.u   = ((jx & ~mask) << 1) | (jx & mask);
    a.v   = a.u | one_b;
    a.tw  = base + (jx >> b);
    return a;
  endfunction

  // Address set for the butterfly that the next edge would issue.
  always_comb begin
    issue_j     = '0;
    issue_stage = '0;
    issue_mode  = mode;
    case (state)
      S_RUN: begin
        issue_j     = j + JW'(1);
        issue_stage = stage;
        issue_mode  = sel_ntt;
      end
      S_DRAIN: begin
        issue_j     = '0;
        issue_stage = stage + 4'd1;
        issue_mode  = sel_ntt;
      end
      default: ;
    endcase
    issue_a = gen_addr(issue_j, issue_stage, issue_mode);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      j         <= '0;
      cnt       <= '0;
      stage     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sel_ntt   <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_u <= '0;
      rd_addr_v <= '0;
      tw_addr   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= S_RUN;
            sel_ntt   <= mode;
            stage     <= '0;
            j         <= '0;
            busy      <= 1'b1;
            rd_en     <= 1'b1;
            rd_addr_u <= issue_a.u;
            rd_addr_v <= issue_a.v;
            tw_addr   <= issue_a.tw;
          end
        end
        S_RUN: begin
          if (j == J_LAST) begin
            state <= S_DRAIN;
            rd_en <= 1'b0;
            cnt   <= DRAIN_INIT;
          end else begin
            j         <= issue_j;
            rd_en     <= 1'b1;
            rd_addr_u <= issue_a.u;
            rd_addr_v <= issue_a.v;
            tw_addr   <= issue_a.tw;
          end
        end
        S_DRAIN: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (stage < LAST_STAGE) begin
            state     <= S_RUN;
            stage     <= issue_stage;
            j         <= '0;
            rd_en     <= 1'b1;
            rd_addr_u <= issue_a.u;
            rd_addr_v <= issue_a.v;
            tw_addr   <= issue_a.tw;
          end else begin
            state <= S_FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Write-back delay line: issue strobe and u/v addresses delayed by
  // exactly PIPE_LAT cycles. Cleared on reset so no stale write survives.
  logic [DW-1:0] dly [PIPE_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) dly[i] <= '0;
    end else begin
      dly[0] <= {rd_en, rd_addr_u, rd_addr_v};
      for (int i = 1; i < PIPE_LAT; i++) dly[i] <= dly[i-1];
    end
  end

  assign {wr_en, wr_addr_u, wr_addr_v} = dly[PIPE_LAT-1];

endmodule

// File: tb/tb_ntt_bf_scheduler.sv
// Directed bench for ntt_bf_scheduler: default 512-point instance plus a
// 16-point / PIPE_LAT=3 instance.
module tb_ntt_bf_scheduler;

  localparam int LN = 9, N = 512, H = 256, L = 7, P = H + L, TOTAL = LN * P;
  localparam int SLN = 4, SN = 16, SH = 8, SL = 3, SP = SH + SL, STOTAL = SLN * SP;

  logic clk = 1'b0;
  logic rst, start, mode;
  logic busy, done, sel_ntt, rd_en, wr_en;
  logic [8:0] rd_addr_u, rd_addr_v, tw_addr, wr_addr_u, wr_addr_v;
  logic [3:0] stage;

  logic start_s, mode_s;
  logic busy_s, done_s, sel_s, rd_en_s, wr_en_s;
  logic [3:0] rd_u_s, rd_v_s, tw_s, wr_u_s, wr_v_s, stage_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ntt_bf_scheduler #(.LOG_N(9), .PIPE_LAT(7)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .busy(busy), .done(done), .sel_ntt(sel_ntt), .rd_en(rd_en),
    .rd_addr_u(rd_addr_u), .rd_addr_v(rd_addr_v), .tw_addr(tw_addr),
    .wr_en(wr_en), .wr_addr_u(wr_addr_u), .wr_addr_v(wr_addr_v),
    .stage(stage)
  );

  ntt_bf_scheduler #(.LOG_N(4), .PIPE_LAT(3)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .mode(mode_s),
    .busy(busy_s), .done(done_s), .sel_ntt(sel_s), .rd_en(rd_en_s),
    .rd_addr_u(rd_u_s), .rd_addr_v(rd_v_s), .tw_addr(tw_s),
    .wr_en(wr_en_s), .wr_addr_u(wr_u_s), .wr_addr_v(wr_v_s),
    .stage(stage_s)
  );

  // Reference schedule from the textbook loop nest: span t, group i,
  // offset k within the group; u = 2*i*t + k, v = u + t, tw = m + i.
  function automatic void exp_issue(input int c, input logic m, output bit en,
                                    output int u, output int v, output int tw);
    int s, off, t, i, k;
    en = 0; u = 0; v = 0; tw = 0;
    if (c < 1) return;
    s   = (c - 1) / P;
    off = (c - 1) % P;
    if (s >= LN || off >= H) return;
    en = 1;
    t  = m ? (1 << s) : (N >> (s + 1));
    i  = off / t;
    k  = off % t;
    u  = 2 * i * t + k;
    v  = u + t;
    tw = N / (2 * t) + i;
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = 1'b0; start_s = 1'b0; mode_s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, sel_ntt, rd_en, rd_addr_u, rd_addr_v, tw_addr, wr_en,
         wr_addr_u, wr_addr_v, stage} !== 54'd0) begin
      errors++;
      $display("FAIL reset_main got busy=%b done=%b rd_en=%b wr_en=%b stage=%0d want all 0",
               busy, done, rd_en, wr_en, stage);
    end
    checks++;
    if ({busy_s, done_s, sel_s, rd_en_s, wr_en_s, stage_s} !== 9'd0) begin
      errors++;
      $display("FAIL reset_small got busy=%b done=%b rd_en=%b wr_en=%b want all 0",
               busy_s, done_s, rd_en_s, wr_en_s);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, rd_en, wr_en} !== 4'd0) begin
      errors++;
      $display("FAIL idle_after_reset got busy/done/rd/wr=%b want 0000",
               {busy, done, rd_en, wr_en});
    end
  endtask

  // Full transform against the reference schedule. With pulse_extra,
  // start is re-pulsed mid-run and in the last DRAIN cycle, and mode is
  // flipped after acceptance; neither may disturb the run.
  task automatic test_transform(input logic m, input bit pulse_extra);
    logic [53:0] exp_v, act_v;
    bit e_rd, e_wr;
    int eu, ev, etw, ewu, ewv, ejunk, es, n_rd, n_wr;
    n_rd = 0; n_wr = 0;
    start = 1'b1; mode = m;
    @(posedge clk); #1;
    start = 1'b0; mode = ~m;
    for (int c = 1; c <= TOTAL + 1; c++) begin
      exp_issue(c, m, e_rd, eu, ev, etw);
      exp_issue(c - L, m, e_wr, ewu, ewv, ejunk);
      es = (c - 1) / P;
      if (es > LN - 1) es = LN - 1;
      exp_v = {c <= TOTAL, c == TOTAL + 1, m, e_rd,
               e_rd ? 9'(eu) : 9'd0, e_rd ? 9'(ev) : 9'd0, e_rd ? 9'(etw) : 9'd0,
               e_wr, e_wr ? 9'(ewu) : 9'd0, e_wr ? 9'(ewv) : 9'd0, 4'(es)};
      act_v = {busy, done, sel_ntt, rd_en,
               e_rd ? rd_addr_u : 9'd0, e_rd ? rd_addr_v : 9'd0, e_rd ? tw_addr : 9'd0,
               wr_en, e_wr ? wr_addr_u : 9'd0, e_wr ? wr_addr_v : 9'd0, stage};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL sched mode=%0d cycle=%0d got=%h want=%h", m, c, act_v, exp_v);
      end
      if (rd_en === 1'b1) n_rd++;
      if (wr_en === 1'b1) n_wr++;

      if (!m && c == 1) begin
        checks++;
        if ({rd_en, rd_addr_u, rd_addr_v, tw_addr} !== {1'b1, 9'd0, 9'd256, 9'd1}) begin
          errors++;
          $display("FAIL ntt_first_issue got u=%0d v=%0d tw=%0d want u=0 v=256 tw=1",
                   rd_addr_u, rd_addr_v, tw_addr);
        end
      end
      if (!m && c == 256) begin
        checks++;
        if ({rd_en, rd_addr_u, rd_addr_v, tw_addr} !== {1'b1, 9'd255, 9'd511, 9'd1}) begin
          errors++;
          $display("FAIL ntt_s0_j255 got u=%0d v=%0d tw=%0d want u=255 v=511 tw=1",
                   rd_addr_u, rd_addr_v, tw_addr);
        end
      end
      if (!m && c == 2110) begin
        checks++;
        if ({rd_en, rd_addr_u, rd_addr_v, tw_addr} !== {1'b1, 9'd10, 9'd11, 9'd261}) begin
          errors++;
          $display("FAIL ntt_s8_j5 got u=%0d v=%0d tw=%0d want u=10 v=11 tw=261",
                   rd_addr_u, rd_addr_v, tw_addr);
        end
      end
      if (m && c == 4) begin
        checks++;
        if ({rd_en, rd_addr_u, rd_addr_v, tw_addr} !== {1'b1, 9'd6, 9'd7, 9'd259}) begin
          errors++;
          $display("FAIL intt_s0_j3 got u=%0d v=%0d tw=%0d want u=6 v=7 tw=259",
                   rd_addr_u, rd_addr_v, tw_addr);
        end
      end
      if (m && c == 2108) begin
        checks++;
        if ({rd_en, rd_addr_u, rd_addr_v, tw_addr} !== {1'b1, 9'd3, 9'd259, 9'd1}) begin
          errors++;
          $display("FAIL intt_s8_j3 got u=%0d v=%0d tw=%0d want u=3 v=259 tw=1",
                   rd_addr_u, rd_addr_v, tw_addr);
        end
      end
      if (c == 263) begin
        checks++;
        if ({wr_en, rd_en} !== 2'b10) begin
          errors++;
          $display("FAIL last_s0_write got wr/rd=%b want 10", {wr_en, rd_en});
        end
      end
      if (c == 264) begin
        checks++;
        if ({wr_en, rd_en} !== 2'b01) begin
          errors++;
          $display("FAIL first_s1_read got wr/rd=%b want 01", {wr_en, rd_en});
        end
      end
      if (c == 2368) begin
        checks++;
        if ({busy, done} !== 2'b01) begin
          errors++;
          $display("FAIL done_cycle got busy/done=%b want 01", {busy, done});
        end
      end

      start = pulse_extra && (c == 100 || c == 2367);
      if (pulse_extra) mode = ~m;
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++;
    if (n_rd != 2304) begin
      errors++;
      $display("FAIL rd_count mode=%0d got %0d want 2304", m, n_rd);
    end
    checks++;
    if (n_wr != 2304) begin
      errors++;
      $display("FAIL wr_count mode=%0d got %0d want 2304", m, n_wr);
    end
    checks++;
    if ({busy, done, rd_en, wr_en} !== 4'd0) begin
      errors++;
      $display("FAIL after_done got busy/done/rd/wr=%b want 0000", {busy, done, rd_en, wr_en});
    end
  endtask

  task automatic test_mid_reset();
    start = 1'b1; mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (498) @(posedge clk);
    #1;
    checks++;
    if ({busy, wr_en} !== 2'b11) begin
      errors++;
      $display("FAIL pre_reset_c499 got busy/wr=%b want 11", {busy, wr_en});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      checks++;
      if ({busy, wr_en, rd_en, done} !== 4'd0) begin
        errors++;
        $display("FAIL post_reset k=%0d got busy/wr/rd/done=%b want 0000",
                 k, {busy, wr_en, rd_en, done});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_small(input logic m);
    int cov [SLN][SN];
    int s, n_wr;
    n_wr = 0;
    for (int a = 0; a < SLN; a++)
      for (int b = 0; b < SN; b++) cov[a][b] = 0;
    start_s = 1'b1; mode_s = m;
    @(posedge clk); #1;
    start_s = 1'b0;
    for (int c = 1; c <= STOTAL + 1; c++) begin
      checks++;
      if ({busy_s, done_s} !== {c <= STOTAL, c == STOTAL + 1}) begin
        errors++;
        $display("FAIL small_timing mode=%0d cycle=%0d got busy/done=%b want %b",
                 m, c, {busy_s, done_s}, {c <= STOTAL, c == STOTAL + 1});
      end
      if (rd_en_s === 1'b1) begin
        s = (c - 1) / SP;
        if (s < SLN) begin
          cov[s][rd_u_s]++;
          cov[s][rd_v_s]++;
        end
        checks++;
        if (tw_s === 4'd0) begin
          errors++;
          $display("FAIL small_tw_nonzero cycle=%0d got 0 want nonzero", c);
        end
      end
      if (wr_en_s === 1'b1) n_wr++;
      @(posedge clk); #1;
    end
    for (int a = 0; a < SLN; a++)
      for (int b = 0; b < SN; b++) begin
        checks++;
        if (cov[a][b] != 1) begin
          errors++;
          $display("FAIL small_cover mode=%0d stage=%0d addr=%0d got %0d want 1",
                   m, a, b, cov[a][b]);
        end
      end
    checks++;
    if (n_wr != SLN * SH) begin
      errors++;
      $display("FAIL small_wr_count got %0d want %0d", n_wr, SLN * SH);
    end
  endtask

  initial begin
    test_reset();
    test_transform(1'b0, 1'b1);
    test_transform(1'b1, 1'b0);
    test_mid_reset();
    test_small(1'b0);
    test_small(1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ntt_bf_scheduler.md
Name: ntt_bf_scheduler

Overview:
Stage/address sequencer for the single radix-2 butterfly unit used by the 512-point NTT/INTT (q = 12289, 14-bit coefficients).
- Per stage, issues one butterfly per cycle: u/v read addresses, twiddle address and the `sel_ntt` mode bit.
- Produces the matching write-back strobe and addresses, aligned to the butterfly pipeline latency.
- Inserts a drain bubble between stages so that no read overtakes a pending write.
- Sits between the top-level controller (`start`/`done`) and the coefficient RAM, twiddle ROM and butterfly datapath.

Parameters:
- LOG_N, 9, log2 of transform size; N = 2^LOG_N, N/2 butterflies per stage, LOG_N stages.
- PIPE_LAT, 7, cycles from read-address issue to butterfly result valid. Default is 1 RAM read plus 6 butterfly cycles (two 3-deep shifters).

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, begin a transform; sampled only in IDLE.
- mode, input, 1, 0 = forward NTT (Cooley-Tukey), 1 = INTT (Gentleman-Sande); latched on accepted start.
- busy, output, 1, high from the first issue cycle through the last write-back.
- done, output, 1, one-cycle pulse after the last write-back.
- sel_ntt, output, 1, latched mode, driven to the butterfly and the twiddle-table select; stable while busy.
- rd_en, output, 1, read/issue strobe.
- rd_addr_u, output, LOG_N, u read address.
- rd_addr_v, output, LOG_N, v read address.
- tw_addr, output, LOG_N, twiddle ROM address.
- wr_en, output, 1, write-back strobe.
- wr_addr_u, output, LOG_N, write address for `bf_lower`.
- wr_addr_v, output, LOG_N, write address for `bf_upper`.
- stage, output, 4, current stage index 0..LOG_N-1.

Behaviour:
- **Reset:** state IDLE. All outputs 0; `stage` = 0; write delay line cleared.
  - Reset mid-transform aborts immediately. No `wr_en` may appear after reset is applied.
- **States:**
  - IDLE: `start`=1 latches `mode`, sets `stage` = 0 and `j` = 0, then goes to RUN.
  - RUN: `rd_en` = 1 every cycle and `j` increments. After `j` = N/2-1 go to DRAIN.
  - DRAIN: lasts exactly PIPE_LAT cycles, `rd_en` = 0. At exit:
    - `stage` < LOG_N-1: increment `stage`, clear `j`, go to RUN.
    - otherwise: go to DONE.
  - DONE: `done` = 1 for one cycle, then IDLE.
- **Address generation** (all outputs registered, valid when `rd_en` = 1):
  - Butterfly counter `j` is LOG_N-1 bits.
  - Half-span exponent: b = LOG_N-1-stage for NTT, b = stage for INTT.
  - Addresses insert one bit at position b of `j`: `rd_addr_u` = {j[LOG_N-2:b], 0, j[b-1:0]}, `rd_addr_v` = {j[LOG_N-2:b], 1, j[b-1:0]}.
  - Twiddle: group = j >> b; `tw_addr` = (1<<stage) + group for NTT, (2^(LOG_N-1) >> stage) + group for INTT. `tw_addr` is never 0.
- **Write alignment:** `wr_en`, `wr_addr_u` and `wr_addr_v` equal `rd_en`, `rd_addr_u` and `rd_addr_v` delayed by exactly PIPE_LAT cycles. Implement as a shift register.
- **Timing** (`start` accepted at cycle 0, L = PIPE_LAT):
  - Stage s issues at cycles 1+s·(N/2+L) through s·(N/2+L)+N/2.
  - The last write of each stage lands on the final DRAIN cycle.
  - `busy` is high for cycles 1..LOG_N·(N/2+L).
  - `done` fires at cycle LOG_N·(N/2+L)+1, which is 2368 for the defaults; `busy` = 0 in that cycle.
- **Input handling:**
  - `start` while busy or in DONE is ignored, with no re-latching of `mode`.
  - `start` held high in IDLE after DONE launches a new transform.
- **Consistency:** `sel_ntt` never changes while `busy` = 1.
- **Throughput:** 256 butterflies per stage with no stall input; downstream must accept one write per cycle.

Test Plan:
1. NTT default params, `start` at cycle 0:
   - First issue cycle 1: u=0, v=256, tw=1.
   - Stage 0, `j`=255: u=255, v=511.
   - Stage 8, `j`=5: u=10, v=11, tw=261.
   - `done` at cycle 2368, 2304 `rd_en` and 2304 `wr_en` pulses.
2. INTT:
   - Stage 0, `j`=3: u=6, v=7, tw=259.
   - Stage 8, `j`=3: u=3, v=259, tw=1.
   - `sel_ntt`=1 throughout.
3. Write alignment: in every cycle, `wr_addr_u`/`wr_addr_v` equal the `rd_addr` values from 7 cycles earlier. No cycle in which a `wr_addr` equals a pending read of the next stage: first stage-1 read at cycle 264, last stage-0 write at cycle 263.
4. Pulse `start` at cycles 0, 100 and 2367: only one transform runs and `mode` is unchanged. A `start` at cycle 2369 (IDLE) launches a second run.
5. Assert `rst` at cycle 500 for one cycle: from the next edge `busy`, `wr_en`, `rd_en` and `done` are 0 and stay 0 until a new `start`.
6. PIPE_LAT=3, LOG_N=4: 4 stages × (8+3) cycles, `done` at cycle 45; all 16 addresses are covered exactly once per stage.
